// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter
// Shares one I2C write controller between NUM_REQ requesters. Requests are
// granted round-robin, the granted 24-bit word is handed to the controller
// with a GO/END handshake, ACK is checked, and failed attempts (NACK or no
// END within TIMEOUT cycles) are retried up to MAX_RETRY extra times.
//
// Ports
//   CLOCK_50   system clock (50 MHz)
//   iRST_N     asynchronous active-low reset
//   req_valid  per-requester request, held high until its done/err pulse
//   req_data   requester i word at [24i+23:24i]
//   req_done   1-cycle pulse: transfer ACKed
//   req_err    1-cycle pulse: retries exhausted
//   i2c_go     start transfer to the controller
//   i2c_data   word to the controller
//   i2c_end    controller END (asynchronous, synchronised here)
//   i2c_ack    controller ACK flag, 1 = failure (asynchronous, synchronised here)
//   busy       high whenever the FSM is not idle
//   grant_id   index of the requester being served
//   dbgState   current FSM state, for checkers
//
// Handshake: a requester raises req_valid with req_data and keeps it high
// until it sees exactly one req_done or req_err pulse on its bit; its word
// is captured at grant, so later changes of req_data or req_valid do not
// affect the transfer in flight. Towards the controller, i2c_go is raised
// with i2c_data stable and held until END is seen (or the timeout hits);
// a new GO is only issued once END has returned low.
module i2c_cfg_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 2500000,
  parameter int ID_W      = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   iRST_N,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [24*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   i2c_go,
  output logic [23:0]            i2c_data,
  input  logic                   i2c_end,
  input  logic                   i2c_ack,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic [2:0]             dbgState
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_END = 3'd2,
    CHECK    = 3'd3,
    FAIL     = 3'd4,
    DONE     = 3'd5,
    END_LOW  = 3'd6
  } state_t;

  state_t state, stateNext;

  logic            endMeta, endSync;
  logic            ackMeta, ackSync;
  logic [ID_W-1:0] lastGrant;
  logic [RC_W-1:0] retryCnt;
  logic            retryPend;
  logic [TO_W-1:0] toCnt;

  logic            anyReq;
  logic [ID_W-1:0] pickId;
  logic [23:0]     pickData;
  logic            canRetry;

  // Two-flop synchronisers for the controller's slow-domain flags.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      endMeta <= 1'b0;
      endSync <= 1'b0;
      ackMeta <= 1'b0;
      ackSync <= 1'b0;
    end else begin
      endMeta <= i2c_end;
      endSync <= endMeta;
      ackMeta <= i2c_ack;
      ackSync <= ackMeta;
    end
  end

  // Round-robin pick: scan lastGrant+1, +2, ... The loop runs from the
  // farthest offset to the nearest so the nearest valid requester is the
  // last assignment and therefore wins.
  always_comb begin
    anyReq   = 1'b0;
    pickId   = '0;
    pickData = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j == (int'(lastGrant) + k) % NUM_REQ) && req_valid[j]) begin
          anyReq   = 1'b1;
          pickId   = ID_W'(j);
          pickData = req_data[24*j +: 24];
        end
      end
    end
  end

  assign canRetry = int'(retryCnt) < MAX_RETRY;

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (anyReq) stateNext = START;
      START:    stateNext = WAIT_END;
      WAIT_END: begin
        if (endSync)               stateNext = CHECK;
        else if (toCnt == TO_LAST) stateNext = FAIL;
      end
      CHECK:    stateNext = ackSync ? FAIL : DONE;
      FAIL:     stateNext = END_LOW;
      DONE:     stateNext = END_LOW;
      // Hold off the next GO until END has dropped so a stale END from
      // the previous transfer cannot complete the next one.
      END_LOW:  if (!endSync) stateNext = retryPend ? START : IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // GO, busy and the pulses decode straight from the state register, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    i2c_go   = (state == START) || (state == WAIT_END);
    busy     = (state != IDLE);
    req_done = '0;
    req_err  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == grant_id) begin
        req_done[j] = (state == DONE);
        req_err[j]  = (state == FAIL) && !canRetry;
      end
    end
  end

  assign dbgState = state;

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      lastGrant <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      i2c_data  <= '0;
      retryCnt  <= '0;
      retryPend <= 1'b0;
      toCnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant_id  <= pickId;
            i2c_data  <= pickData;
            retryCnt  <= '0;
            retryPend <= 1'b0;
          end
        end
        START: begin
          toCnt     <= '0;
          retryPend <= 1'b0;
        end
        WAIT_END: begin
          if (!endSync && (toCnt != TO_LAST)) toCnt <= toCnt + 1'b1;
        end
        FAIL: begin
          if (canRetry) begin
            retryCnt  <= retryCnt + 1'b1;
            retryPend <= 1'b1;
          end
        end
        DONE: lastGrant <= grant_id;
        END_LOW: begin
          // Covers the error path too: the failed requester still moves
          // to the back of the round-robin order.
          if (!endSync && !retryPend) lastGrant <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
module tb_i2c_cfg_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 100;
  localparam int ID_W      = 2;
  localparam int EW        = 31;  // {err, idx[1:0], data[23:0], attempts[3:0]}

  localparam int K_ACK   = 0;
  localparam int K_NACK  = 1;
  localparam int K_NOEND = 2;
  localparam int K_MIX   = 3;

  // ---------------- clock / reset ----------------
  logic                  CLOCK_50 = 1'b0;
  logic                  iRST_N   = 1'b0;
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_err;
  logic                  i2c_go;
  logic [23:0]           i2c_data;
  logic                  i2c_end;
  logic                  i2c_ack;
  logic                  busy;
  logic [ID_W-1:0]       grant_id;
  logic [2:0]            dbgState;

  always #10 CLOCK_50 = ~CLOCK_50;

  i2c_cfg_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .iRST_N(iRST_N),
    .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .req_err(req_err),
    .i2c_go(i2c_go), .i2c_data(i2c_data),
    .i2c_end(i2c_end), .i2c_ack(i2c_ack),
    .busy(busy), .grant_id(grant_id), .dbgState(dbgState)
  );

  // ---------------- shared bench state ----------------
  logic [23:0]   reqQ[NUM_REQ][$];     // words each requester still has to send
  int            planQ[$];             // controller response per GO, in order
  logic [EW-1:0] exp_q[$];             // expected completion events
  logic [23:0]   pendData[NUM_REQ][$];
  int            pendFails[NUM_REQ][$];
  int            pendKind[NUM_REQ][$];
  int            modelLast = NUM_REQ - 1;
  int            endHold   = 2;
  bit            chaos     = 1'b0;
  int            nChecks   = 0;
  int            nPass     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [EW-1:0] mkEvt(input logic err, input int idx,
                                          input logic [23:0] d, input int att);
    return {err, 2'(idx), d, 4'(att)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic addTxn(input int r, input logic [23:0] d, input int fails, input int kind);
    pendData[r].push_back(d);
    pendFails[r].push_back(fails);
    pendKind[r].push_back(kind);
  endtask

  // Reference model: serve pending words round-robin from the last served
  // requester; a word with f failures needs min(f+1, 1+MAX_RETRY) GOs and
  // ends in an error when f exceeds MAX_RETRY.
  task automatic runBatch(input string tag);
    int pick, f, kd, att, rem;
    logic [23:0] d;
    forever begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (pick < 0 && pendData[(modelLast + k) % NUM_REQ].size() > 0)
          pick = (modelLast + k) % NUM_REQ;
      end
      if (pick < 0) break;
      d  = pendData[pick].pop_front();
      f  = pendFails[pick].pop_front();
      kd = pendKind[pick].pop_front();
      att = (f <= MAX_RETRY) ? f + 1 : MAX_RETRY + 1;
      for (int a = 0; a < att; a++) begin
        if (a == f)            planQ.push_back(K_ACK);
        else if (kd == K_MIX)  planQ.push_back(($urandom_range(0, 3) == 0) ? K_NOEND : K_NACK);
        else                   planQ.push_back(kd);
      end
      exp_q.push_back(mkEvt(f > MAX_RETRY, pick, d, att));
      reqQ[pick].push_back(d);
      modelLast = pick;
    end
    rem = 1;
    for (int c = 0; c < 30000 && rem != 0; c++) begin
      @(negedge CLOCK_50);
      rem = exp_q.size() + int'(busy);
      for (int i = 0; i < NUM_REQ; i++) rem += reqQ[i].size();
    end
    chk({"drain_", tag}, rem, 0);
    chk({"plan_used_", tag}, planQ.size(), 0);
    @(posedge CLOCK_50);
    #2;
  endtask

  // ---------------- requester model ----------------
  // Drops its bit after the done/err pulse for its last word. While GO is
  // high the words are scrambled (and with chaos, valid dropped) to show
  // that only the word captured at grant is used.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((req_done[i] || req_err[i]) && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        if (reqQ[i].size() > 0) begin
          req_valid[i]        = !(chaos && i2c_go);
          req_data[24*i +: 24] = i2c_go ? 24'($urandom) : reqQ[i][0];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[24*i +: 24] = '0;
        end
      end
    end
  end

  // ---------------- I2C controller model ----------------
  initial begin
    int kind, d, k;
    i2c_end = 1'b0;
    i2c_ack = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_go) begin
        kind = (planQ.size() > 0) ? planQ.pop_front() : K_ACK;
        if (kind == K_NOEND) begin
          while (i2c_go) @(negedge CLOCK_50);
        end else begin
          d = $urandom_range(1, 6);
          k = 0;
          while (k < d && i2c_go) begin
            @(negedge CLOCK_50);
            k++;
          end
          if (i2c_go) begin
            i2c_ack = (kind == K_NACK);
            i2c_end = 1'b1;
            while (i2c_go) @(negedge CLOCK_50);
            repeat (endHold) @(negedge CLOCK_50);
            i2c_end = 1'b0;
            i2c_ack = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int   attempts  = 0;
  int   goLen     = 0;
  bit   goPrev    = 1'b0;
  bit   pulsePrev = 1'b0;
  bit   sawEnd    = 1'b0;
  int   obsIdx;
  logic [EW-1:0] e;

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!iRST_N) begin
        attempts  = 0;
        goLen     = 0;
        goPrev    = 1'b0;
        pulsePrev = 1'b0;
        sawEnd    = 1'b0;
      end else begin
        if (pulsePrev) chk("pulse_width", {req_done, req_err}, 0);
        if (i2c_go && !goPrev) begin
          chk("go_while_end_high", i2c_end, 0);
          if (exp_q.size() > 0) begin
            chk("go_data", i2c_data, exp_q[0][27:4]);
            chk("go_grant_id", grant_id, exp_q[0][29:28]);
          end
          attempts++;
          goLen  = 0;
          sawEnd = 1'b0;
        end
        if (i2c_go) begin
          goLen++;
          if (i2c_end) sawEnd = 1'b1;
        end
        if (!i2c_go && goPrev && !sawEnd)
          chk("timeout_go_len", (goLen >= TIMEOUT) && (goLen <= TIMEOUT + 2), 1);
        if ((req_done | req_err) != '0) begin
          obsIdx = 0;
          for (int i = 0; i < NUM_REQ; i++) if (req_done[i] || req_err[i]) obsIdx = i;
          chk("pulse_onehot", $countones({req_done, req_err}), 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {|req_err, 2'(obsIdx), 4'(attempts)}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("evt_kind", |req_err, e[30]);
            chk("evt_idx", obsIdx, e[29:28]);
            chk("evt_grant_id", grant_id, e[29:28]);
            chk("evt_attempts", attempts, e[3:0]);
          end
          attempts = 0;
        end
        pulsePrev = ((req_done | req_err) != '0);
        goPrev    = i2c_go;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, c;
    repeat (3) @(posedge CLOCK_50);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_go", i2c_go, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_err, 0);
    iRST_N = 1'b1;
    @(posedge CLOCK_50);
    #2;

    // Contention from reset: expect 0,1,0,1.
    for (int t = 0; t < 2; t++) begin
      addTxn(0, 24'($urandom), 0, K_ACK);
      addTxn(1, 24'($urandom), 0, K_ACK);
    end
    runBatch("contend");

    addTxn(0, 24'h340017, 0, K_ACK);
    runBatch("single");

    addTxn(1, 24'($urandom), 2, K_NACK);
    runBatch("nack2");
    addTxn(0, 24'($urandom), MAX_RETRY + 1, K_NACK);
    runBatch("nack_all");

    addTxn(1, 24'($urandom), MAX_RETRY + 1, K_NOEND);
    runBatch("timeout");

    endHold = 40;
    addTxn(0, 24'($urandom), 0, K_ACK);
    addTxn(1, 24'($urandom), 0, K_ACK);
    addTxn(0, 24'($urandom), 1, K_NACK);
    runBatch("stale_end");
    endHold = 2;

    chaos = 1'b1;
    for (int b = 0; b < 6; b++) begin
      endHold = $urandom_range(0, 5);
      for (int r = 0; r < NUM_REQ; r++) begin
        n = $urandom_range(0, 3);
        for (int t = 0; t < n; t++)
          addTxn(r, 24'($urandom), $urandom_range(0, MAX_RETRY + 1), K_MIX);
      end
      runBatch("random");
    end
    chaos   = 1'b0;
    endHold = 2;

    // Reset while requester 1 is waiting for END.
    reqQ[1].push_back(24'hA5C30F);
    planQ.push_back(K_NOEND);
    c = 0;
    while (c < 200 && !i2c_go) begin
      @(negedge CLOCK_50);
      c++;
    end
    chk("rst_mid_go_seen", i2c_go, 1);
    repeat (10) @(posedge CLOCK_50);
    #3;
    iRST_N = 1'b0;
    #1;
    chk("rst_mid_go", i2c_go, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", req_done, 0);
    chk("rst_mid_err", req_err, 0);
    for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
    planQ.delete();
    exp_q.delete();
    modelLast = NUM_REQ - 1;
    repeat (2) @(posedge CLOCK_50);
    #2;
    iRST_N = 1'b1;
    @(posedge CLOCK_50);
    #2;

    addTxn(1, 24'($urandom), 0, K_ACK);
    addTxn(0, 24'($urandom), 1, K_NACK);
    runBatch("post_reset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
    $display("%0d/%0d checks passed", nPass, nChecks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
